otg_hpi_arbiter: RTL and testbench

//  Sequences timed read/write cycles on the CY7C67200 HPI port (cs/addr/rd/wr/16-bit data).

---
 rtl/otg_hpi_arbiter.sv | 168 ++++++++++++++++
 tb/tb_otg_hpi_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/otg_hpi_arbiter.sv
// Two-requester arbiter and cycle sequencer for the CY7C67200 HPI port.
// Optional macro HPI_IRQ_SYNC_EN adds an hpi_int synchronizer and rising-edge pulse on hpi_irq.
module otg_hpi_arbiter #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        poll_req,
    input  logic        poll_we,
    input  logic [1:0]  poll_addr,
    input  logic [15:0] poll_wdata,
    output logic        poll_ack,
    output logic [15:0] poll_rdata,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_dout,
    output logic        hpi_oe,
    input  logic [15:0] hpi_din,
    input  logic        hpi_int,
    output logic        hpi_irq,
    output logic        busy
);

    localparam logic [3:0] SetupLoad  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] StrobeLoad = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HoldLoad   = 4'(HOLD_CYC - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StAck} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        sel_poll_q, sel_poll_d;   // requester owning the current access
    logic        last_poll_q, last_poll_d; // last grant went to the poller
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] poll_rdata_q, poll_rdata_d;
    logic        grant_poll;
    logic        active;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 2'd0;
            wdata_q      <= 16'd0;
            sel_poll_q   <= 1'b0;
            last_poll_q  <= 1'b1;
            cpu_rdata_q  <= 16'd0;
            poll_rdata_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sel_poll_q   <= sel_poll_d;
            last_poll_q  <= last_poll_d;
            cpu_rdata_q  <= cpu_rdata_d;
            poll_rdata_q <= poll_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q - 4'd1;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sel_poll_d   = sel_poll_q;
        last_poll_d  = last_poll_q;
        cpu_rdata_d  = cpu_rdata_q;
        poll_rdata_d = poll_rdata_q;
        // On a tie the poller wins only if the CPU was served last.
        grant_poll   = poll_req && (!cpu_req || !last_poll_q);

        unique case (state_q)
            StIdle: begin
                cnt_d = cnt_q;
                if (cpu_req || poll_req) begin
                    sel_poll_d  = grant_poll;
                    last_poll_d = grant_poll;
                    we_d        = grant_poll ? poll_we    : cpu_we;
                    addr_d      = grant_poll ? poll_addr  : cpu_addr;
                    wdata_d     = grant_poll ? poll_wdata : cpu_wdata;
                    cnt_d       = SetupLoad;
                    state_d     = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = StrobeLoad;
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (sel_poll_q) poll_rdata_d = hpi_din;
                        else            cpu_rdata_d  = hpi_din;
                    end
                    cnt_d   = HoldLoad;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == 4'd0) state_d = StAck;
            end
            StAck: begin
                cnt_d   = cnt_q;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        active     = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
        hpi_cs_n   = !active;
        hpi_rd_n   = !((state_q == StStrobe) && !we_q);
        hpi_wr_n   = !((state_q == StStrobe) && we_q);
        hpi_oe     = active && we_q;
        hpi_addr   = active ? addr_q : 2'd0;
        hpi_dout   = hpi_oe ? wdata_q : 16'd0;
        cpu_ack    = (state_q == StAck) && !sel_poll_q;
        poll_ack   = (state_q == StAck) && sel_poll_q;
        cpu_rdata  = cpu_rdata_q;
        poll_rdata = poll_rdata_q;
        busy       = (state_q != StIdle);
    end

`ifdef HPI_IRQ_SYNC_EN
    logic [2:0] int_sync_q;
    logic       irq_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            int_sync_q <= 3'd0;
            irq_q      <= 1'b0;
        end else begin
            int_sync_q <= {int_sync_q[1:0], hpi_int};
            irq_q      <= int_sync_q[1] && !int_sync_q[2];
        end
    end

    assign hpi_irq = irq_q;
`else
    logic unused_hpi_int;
    assign unused_hpi_int = hpi_int;
    assign hpi_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_otg_hpi_arbiter.sv
// Directed self-checking bench for otg_hpi_arbiter at default timing (S=2, P=4, H=2).
module tb_otg_hpi_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [1:0]  cpu_addr = 2'd0;
    logic [15:0] cpu_wdata = 16'd0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        poll_req = 1'b0, poll_we = 1'b0;
    logic [1:0]  poll_addr = 2'd0;
    logic [15:0] poll_wdata = 16'd0;
    logic        poll_ack;
    logic [15:0] poll_rdata;
    logic        hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_oe, hpi_irq, busy;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_dout;
    logic [15:0] hpi_din = 16'd0;
    logic        hpi_int = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    otg_hpi_arbiter dut (
        .clk_clk    (clk),
        .reset_reset(reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .poll_req   (poll_req),
        .poll_we    (poll_we),
        .poll_addr  (poll_addr),
        .poll_wdata (poll_wdata),
        .poll_ack   (poll_ack),
        .poll_rdata (poll_rdata),
        .hpi_cs_n   (hpi_cs_n),
        .hpi_rd_n   (hpi_rd_n),
        .hpi_wr_n   (hpi_wr_n),
        .hpi_addr   (hpi_addr),
        .hpi_dout   (hpi_dout),
        .hpi_oe     (hpi_oe),
        .hpi_din    (hpi_din),
        .hpi_int    (hpi_int),
        .hpi_irq    (hpi_irq),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 1: reset values, then idle for 20 cycles
        step();
        step();
        reset = 1'b0;
        check("rst_cs_n", hpi_cs_n, 1);
        check("rst_rd_n", hpi_rd_n, 1);
        check("rst_wr_n", hpi_wr_n, 1);
        check("rst_oe", hpi_oe, 0);
        check("rst_addr", hpi_addr, 0);
        check("rst_dout", hpi_dout, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_poll_ack", poll_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_poll_rdata", poll_rdata, 0);
        check("rst_irq", hpi_irq, 0);
        for (int k = 0; k < 20; k++) begin
            check("idle_busy", busy, 0);
            step();
        end

        // Test 2: CPU write addr 2 data 0x0500; changes after grant are ignored
        cpu_we = 1'b1;
        cpu_addr = 2'd2;
        cpu_wdata = 16'h0500;
        cpu_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 2) begin
                cpu_wdata = 16'hFFFF;
                cpu_addr = 2'd1;
                cpu_we = 1'b0;
            end
            check("wr_cs_n", hpi_cs_n, (k >= 1 && k <= 8) ? 1'b0 : 1'b1);
            check("wr_oe", hpi_oe, (k >= 1 && k <= 8) ? 1'b1 : 1'b0);
            check("wr_wr_n", hpi_wr_n, (k >= 3 && k <= 6) ? 1'b0 : 1'b1);
            check("wr_rd_n", hpi_rd_n, 1);
            check("wr_dout", hpi_dout, (k >= 1 && k <= 8) ? 16'h0500 : 16'h0000);
            check("wr_addr", hpi_addr, (k >= 1 && k <= 8) ? 2'd2 : 2'd0);
            check("wr_cpu_ack", cpu_ack, (k == 9) ? 1'b1 : 1'b0);
            check("wr_poll_ack", poll_ack, 0);
            if (k == 9) begin
                check("wr_cpu_rdata", cpu_rdata, 0);
                cpu_req = 1'b0;
            end
        end

        // Test 3: poller read addr 0, din=0xBEEF during the strobe
        poll_we = 1'b0;
        poll_addr = 2'd0;
        poll_req = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 3) hpi_din = 16'hBEEF;
            if (k == 7) hpi_din = 16'h0000;
            check("rd_rd_n", hpi_rd_n, (k >= 3 && k <= 6) ? 1'b0 : 1'b1);
            check("rd_wr_n", hpi_wr_n, 1);
            check("rd_oe", hpi_oe, 0);
            check("rd_poll_ack", poll_ack, (k == 9) ? 1'b1 : 1'b0);
            check("rd_cpu_ack", cpu_ack, 0);
            check("rd_cpu_rdata", cpu_rdata, 0);
            if (k == 9) begin
                check("rd_poll_rdata", poll_rdata, 16'hBEEF);
                poll_req = 1'b0;
            end
        end

        // Test 4: both requesting after reset -> CPU, POLL, CPU, POLL
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("arb_rdata_cleared", poll_rdata, 0);
        cpu_we = 1'b0;
        cpu_addr = 2'd3;
        hpi_din = 16'h1234;
        poll_we = 1'b1;
        poll_addr = 2'd1;
        poll_wdata = 16'hA5A5;
        cpu_req = 1'b1;
        poll_req = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            step();
            check("arb_cpu_ack", cpu_ack, (k == 9 || k == 29) ? 1'b1 : 1'b0);
            check("arb_poll_ack", poll_ack, (k == 19 || k == 39) ? 1'b1 : 1'b0);
            check("arb_strobe_excl", hpi_rd_n | hpi_wr_n, 1);
            if (k == 3)  check("arb_cpu_dout", hpi_dout, 16'h0000);
            if (k == 9)  check("arb_cpu_rdata", cpu_rdata, 16'h1234);
            if (k == 10) check("arb_turnaround", busy, 0);
            if (k == 11) check("arb_busy", busy, 1);
            if (k == 13) check("arb_poll_dout", hpi_dout, 16'hA5A5);
            if (k == 14) check("arb_poll_addr", hpi_addr, 2'd1);
            if (k == 19) check("arb_poll_rdata", poll_rdata, 16'h0000);
            if (k == 39) begin
                cpu_req = 1'b0;
                poll_req = 1'b0;
            end
        end
        hpi_din = 16'h0000;

        // Test 5: reset during the 2nd strobe cycle of a write; request stays held
        cpu_we = 1'b1;
        cpu_addr = 2'd2;
        cpu_wdata = 16'h0777;
        cpu_req = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 4) begin
                check("abort_wr_n_pre", hpi_wr_n, 0);
                reset = 1'b1;
            end
            if (k == 5) begin
                check("abort_cs_n", hpi_cs_n, 1);
                check("abort_wr_n", hpi_wr_n, 1);
                check("abort_oe", hpi_oe, 0);
                check("abort_busy", busy, 0);
                reset = 1'b0;
            end
            if (k == 6) begin
                check("resume_cs_n", hpi_cs_n, 0);
                check("resume_wr_n", hpi_wr_n, 1);
            end
            if (k >= 8 && k <= 11) check("resume_strobe", hpi_wr_n, 0);
            check("abort_cpu_ack", cpu_ack, (k == 14) ? 1'b1 : 1'b0);
            if (k == 14) cpu_req = 1'b0;
        end

        // Test 6: interrupt path
        hpi_int = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
`ifdef HPI_IRQ_SYNC_EN
            check("irq_pulse", hpi_irq, (k == 3) ? 1'b1 : 1'b0);
`else
            check("irq_tied", hpi_irq, 0);
`endif
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
